vector_mem_unit: RTL and testbench

- Memory-stage (M) consumer of the vector pipeline.
- Takes the pipeline's 32-bit address, the R-lane store data and the read/write strobes, and serializes each vector access into R byte-wide accesses on a single-port synchronous RAM.
- Returns R-lane load data to the M/WB segment as ReadData.
- Asserts StallM to freeze the pipeline while an access is in progress.

---
 rtl/vector_mem_unit.sv | 148 ++++++++++++++
 tb/tb_vector_mem_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_unit.sv
// vector_mem_unit: memory-stage consumer of the vector pipeline.
// Each vector load/store is serialized into R byte-wide accesses on a
// single-port synchronous RAM, lane 0 at the lowest address. StallM holds
// the pipeline while an access is in flight.
// Optional feature: define VMEM_BOUNDS_CHECK_EN to reject requests that
// would run past MEM_DEPTH or that set address bits above A-1. A rejected
// request goes straight to DONE and pulses MemErr there.
module vector_mem_unit #(
  parameter int I         = 32,
  parameter int N         = 8,
  parameter int R         = 6,
  parameter int A         = 16,
  parameter int MEM_DEPTH = 65536
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MemReadM,
  input  logic           MemWriteM,
  input  logic [I-1:0]   AddressM,
  input  logic [R*N-1:0] WriteDataM,
  output logic [R*N-1:0] ReadData,
  output logic           StallM,
  output logic           MemErr,
  output logic [A-1:0]   ram_addr,
  output logic           ram_we,
  output logic [N-1:0]   ram_wdata,
  input  logic [N-1:0]   ram_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  localparam int CW = $clog2(R + 1);
  localparam logic [CW-1:0] LAST_LOAD  = CW'(R);
  localparam logic [CW-1:0] LAST_STORE = CW'(R - 1);

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  lane_rd;
  logic [A-1:0]   base;
  logic [R*N-1:0] wdata_q;
  logic [R*N-1:0] read_q;
  logic           reject;

  // RAM data for address base+k arrives one cycle later, so it lands in lane cnt-1
  assign lane_rd  = cnt - CW'(1);
  assign ReadData = read_q;

`ifdef VMEM_BOUNDS_CHECK_EN
  logic [I:0] end_addr;
  logic       err_q;

  // A request is out of range if its last byte lies past MEM_DEPTH or the
  // address uses bits the RAM cannot see
  assign end_addr = {1'b0, AddressM} + (I+1)'(R);
  assign reject   = (end_addr > (I+1)'(MEM_DEPTH)) || (|AddressM[I-1:A]);
  assign MemErr   = (state == DONE) && err_q;
`else
  logic unused_cfg;

  // Without the check, upper address bits are simply dropped and the
  // RAM address wraps modulo 2^A
  assign unused_cfg = ^{AddressM[I-1:A], 32'(MEM_DEPTH)};
  assign reject     = 1'b0;
  assign MemErr     = 1'b0;
`endif

  // State, counter and data latches; a store takes priority over a load
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      base    <= '0;
      wdata_q <= '0;
      read_q  <= '0;
`ifdef VMEM_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          cnt <= '0;
`ifdef VMEM_BOUNDS_CHECK_EN
          err_q <= 1'b0;
          if ((MemWriteM || MemReadM) && reject) begin
            err_q <= 1'b1;
            if (!MemWriteM) read_q <= '0;
          end
`endif
          if (MemWriteM) begin
            base    <= AddressM[A-1:0];
            wdata_q <= WriteDataM;
          end else if (MemReadM) begin
            base <= AddressM[A-1:0];
          end
        end
        LOAD: begin
          if (cnt != '0) read_q[lane_rd*N +: N] <= ram_rdata;
          cnt <= cnt + CW'(1);
        end
        STORE: begin
          cnt <= cnt + CW'(1);
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Next-state decode and RAM/stall outputs, all defaulted to idle values
  always_comb begin
    state_next = state;
    StallM     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state)
      IDLE: begin
        if (MemWriteM || MemReadM) begin
          StallM = 1'b1;
          if (reject)         state_next = DONE;
          else if (MemWriteM) state_next = STORE;
          else                state_next = LOAD;
        end
      end
      LOAD: begin
        StallM = 1'b1;
        if (cnt < LAST_LOAD) ram_addr = base + A'(cnt);
        if (cnt == LAST_LOAD) state_next = DONE;
      end
      STORE: begin
        StallM    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = base + A'(cnt);
        ram_wdata = wdata_q[cnt*N +: N];
        if (cnt == LAST_STORE) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_mem_unit.sv
// tb_vector_mem_unit: directed bench for vector_mem_unit in its default
// build (VMEM_BOUNDS_CHECK_EN undefined). A behavioural byte RAM sits on
// the RAM port; expected values are written out by hand.
module tb_vector_mem_unit;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] AddressM;
  logic [47:0] WriteDataM;
  logic [47:0] ReadData;
  logic        StallM;
  logic        MemErr;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [0:65535];

  int          testsRun;
  int          testsFailed;
  int          stallCycles;
  int          weCount;
  int          errCount;
  logic [15:0] addrLog [0:15];
  logic [7:0]  dataLog [0:15];
  logic [47:0] doneReadData;

  vector_mem_unit dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .AddressM   (AddressM),
    .WriteDataM (WriteDataM),
    .ReadData   (ReadData),
    .StallM     (StallM),
    .MemErr     (MemErr),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Free-running pipeline clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port synchronous RAM with one cycle of read latency
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Hold a request until the unit releases the stall, logging RAM traffic
  // on each cycle after the accept cycle
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [47:0] wd);
    bit done;
    MemReadM    = rd;
    MemWriteM   = wr;
    AddressM    = addr;
    WriteDataM  = wd;
    stallCycles = 0;
    weCount     = 0;
    errCount    = 0;
    done        = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (StallM) stallCycles++;
      if (ram_we) weCount++;
      if (MemErr) errCount++;
      if (c > 0 && c <= 16) begin
        addrLog[c-1] = ram_addr;
        dataLog[c-1] = ram_wdata;
      end
      if (!StallM) begin
        doneReadData = ReadData;
        MemReadM     = 1'b0;
        MemWriteM    = 1'b0;
        done         = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checkOutput("stall_timeout", 64'd0, 64'd1);
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    MemReadM    = 1'b0;
    MemWriteM   = 1'b0;
    AddressM    = '0;
    WriteDataM  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_stall",    StallM,   0);
    checkOutput("rst_we",       ram_we,   0);
    checkOutput("rst_addr",     ram_addr, 0);
    checkOutput("rst_readdata", ReadData, 0);
    checkOutput("rst_memerr",   MemErr,   0);
    @(negedge clk);

    // Vector store of 11..66 at 0x10
    applyStimulus(1'b0, 1'b1, 32'h10, 48'h665544332211);
    checkOutput("st_stall", stallCycles, 7);
    checkOutput("st_we",    weCount,     6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("st_addr%0d", i), addrLog[i], 64'h10 + i);
      checkOutput($sformatf("st_data%0d", i), dataLog[i], 64'h11 * (i + 1));
    end
    #1;
    checkOutput("st_idle_after", StallM, 0);
    @(negedge clk);

    // Vector load back from 0x10
    applyStimulus(1'b1, 1'b0, 32'h10, 48'h0);
    checkOutput("ld_stall",    stallCycles,  8);
    checkOutput("ld_we",       weCount,      0);
    checkOutput("ld_readdata", doneReadData, 48'h665544332211);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("ld_addr%0d", i), addrLog[i], 64'h10 + i);
    checkOutput("ld_memerr", errCount, 0);

    // Both strobes high: store wins, ReadData keeps the previous load
    applyStimulus(1'b1, 1'b1, 32'h20, 48'ha6a5a4a3a2a1);
    checkOutput("both_stall",    stallCycles,  7);
    checkOutput("both_we",       weCount,      6);
    checkOutput("both_readdata", doneReadData, 48'h665544332211);
    checkOutput("both_mem20",    mem[16'h20],  8'ha1);
    checkOutput("both_mem25",    mem[16'h25],  8'ha6);

    // Wrapping store (upper address bit ignored) followed by wrapping load
    applyStimulus(1'b0, 1'b1, 32'h0001fffd, 48'hc6c5c4c3c2c1);
    checkOutput("wrap_st_we",   weCount,     6);
    checkOutput("wrap_mem0000", mem[16'h0],  8'hc4);
    checkOutput("wrap_memfffd", mem[16'hfffd], 8'hc1);
    applyStimulus(1'b1, 1'b0, 32'hfffd, 48'h0);
    checkOutput("wrap_addr0", addrLog[0], 16'hfffd);
    checkOutput("wrap_addr1", addrLog[1], 16'hfffe);
    checkOutput("wrap_addr2", addrLog[2], 16'hffff);
    checkOutput("wrap_addr3", addrLog[3], 16'h0000);
    checkOutput("wrap_addr4", addrLog[4], 16'h0001);
    checkOutput("wrap_addr5", addrLog[5], 16'h0002);
    checkOutput("wrap_readdata", doneReadData, 48'hc6c5c4c3c2c1);

    // Reset mid-store: clear the target area, then cut a store at cnt=2
    applyStimulus(1'b0, 1'b1, 32'h40, 48'h0);
    MemWriteM  = 1'b1;
    AddressM   = 32'h40;
    WriteDataM = 48'hf6f5f4f3f2f1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_mid_we_before",   ram_we,   1);
    checkOutput("rst_mid_addr_before", ram_addr, 16'h42);
    reset     = 1'b1;
    MemWriteM = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_mid_stall",    StallM,   0);
    checkOutput("rst_mid_we",       ram_we,   0);
    checkOutput("rst_mid_readdata", ReadData, 0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_mid_idle", StallM, 0);
    checkOutput("rst_mid_mem40", mem[16'h40], 8'hf1);
    checkOutput("rst_mid_mem42", mem[16'h42], 8'hf3);
    checkOutput("rst_mid_mem43", mem[16'h43], 8'h00);
    checkOutput("rst_mid_mem45", mem[16'h45], 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
